bram_wr_arbiter: RTL
====================

# bram_wr_arbiter

Round-robin arbiter sharing the single status-BRAM write port (WR_START/WR_ADDR/WR_DATA/WR_DONE level handshake) among NUM_REQ requesters such as the status monitor and task counters. Each requester presents the same level-held start/address/data handshake it would drive to the BRAM writer directly. The arbiter latches the granted request, runs one BRAM write, and returns a one-cycle done pulse to the owner. A watchdog aborts writes whose WR_DONE never arrives.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- ADDR_W, 32: write address width
- DATA_W, 64: write data width
- TIMEOUT_CYCLES, 1024: max cycles in WRITE before abort; 0 disables the watchdog
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  asynchronous active-low reset
- REQ_START  in  NUM_REQ  per-requester start, level; held high until its REQ_DONE bit is seen
- REQ_ADDR  in  NUM_REQ*ADDR_W  flattened addresses; slice i = [i*ADDR_W +: ADDR_W]
- REQ_DATA  in  NUM_REQ*DATA_W  flattened data, same slicing
- REQ_DONE  out  NUM_REQ  one-cycle completion pulse to the granted requester
- REQ_ERR  out  NUM_REQ  one-cycle pulse, coincident with REQ_DONE, when the write timed out
- WR_START  out  1  BRAM write start, level
- WR_ADDR  out  ADDR_W  BRAM write address
- WR_DATA  out  DATA_W  BRAM write data
- WR_DONE  in  1  BRAM write completion
- BUSY  out  1  high in WRITE and ACK
- GRANT_IDX  out  3  index of current or last granted requester
- TIMEOUT_ERR  out  1  sticky timeout flag
- ERR_CLR  in  1  clears TIMEOUT_ERR

## Operation
- Reset: state IDLE; WR_START=0, WR_ADDR=0, WR_DATA=0, REQ_DONE=0, REQ_ERR=0, BUSY=0, GRANT_IDX=0, TIMEOUT_ERR=0, watchdog=0, rr pointer=NUM_REQ-1, so requester 0 wins first.
- IDLE: if any REQ_START bit is set, grant the first set bit searching from pointer+1 modulo NUM_REQ. Register WR_ADDR/WR_DATA from that slice, WR_START<=1, GRANT_IDX<=index, pointer<=index, watchdog<=0; go WRITE. No request: hold all outputs.
- WRITE: WR_ADDR/WR_DATA are frozen, so requester input changes are ignored. Watchdog increments each cycle.
  - On WR_DONE: WR_START<=0, REQ_DONE[GRANT_IDX]<=1; go ACK.
  - Else if TIMEOUT_CYCLES!=0 and the watchdog reaches TIMEOUT_CYCLES-1: WR_START<=0, REQ_DONE and REQ_ERR[GRANT_IDX]<=1, TIMEOUT_ERR<=1; go ACK.
  - WR_DONE and timeout in the same cycle: WR_DONE wins, no error.
- ACK: REQ_DONE/REQ_ERR<=0; go IDLE. This single cycle lets the owner drop REQ_START before re-arbitration, so a stale start never re-grants.
- WR_DONE outside WRITE is ignored.
- A requester dropping REQ_START while granted does not abort the write; its REQ_DONE still pulses.
- TIMEOUT_ERR: set has priority over ERR_CLR in the same cycle.
- Reset asserted mid-write: everything returns to reset values immediately (asynchronous). No REQ_DONE is issued for the lost write.

## Timing
- REQ_START sampled high in IDLE at cycle 0 -> WR_START, WR_ADDR and WR_DATA valid at cycle 1.
- WR_DONE high at cycle k -> WR_START low and REQ_DONE high at cycle k+1, IDLE at k+2, earliest next WR_START at k+3.
- Minimum per-write occupancy is 4 cycles, assuming WR_DONE arrives the cycle after WR_START.
- Timeout: WR_START rises at cycle 1 -> abort, with REQ_ERR, at cycle TIMEOUT_CYCLES+1.
- Fairness: with all requesters continuously active, each is granted exactly once per NUM_REQ grants.

## Test plan
- Single request: REQ_START[2]=1, addr 0x10, data 0xDEAD_BEEF; WR_DONE 3 cycles after WR_START -> WR_ADDR=0x10, WR_DATA=0xDEADBEEF; REQ_DONE=4'b0100 for exactly one cycle; GRANT_IDX=2.
- Full contention: all four REQ_START held, each dropped on its REQ_DONE and re-raised 2 cycles later -> grant order 0,1,2,3,0,1,… with no requester granted twice consecutively.
- Input change mid-write: REQ_ADDR[0] changes 0x4→0x8 while in WRITE -> WR_ADDR stays 0x4 until done; the next grant uses the current value.
- Timeout: TIMEOUT_CYCLES=8, WR_DONE never asserted -> WR_START falls at cycle 9; REQ_DONE and REQ_ERR pulse for the owner; TIMEOUT_ERR stays 1 until ERR_CLR.
- Same-cycle WR_DONE and timeout (TIMEOUT_CYCLES=8, WR_DONE at cycle 8) -> REQ_DONE pulses, REQ_ERR=0, TIMEOUT_ERR=0.
- ARESETN pulsed low during WRITE -> WR_START=0 immediately, no REQ_DONE; after release, requester 0 is granted first if its start is pending.

Source files
------------

// File: rtl/bram_wr_arbiter.sv
// Round-robin arbiter sharing one status-BRAM write port among NUM_REQ requesters.
// One latched write per grant, done/err pulse back to the owner, watchdog abort.
module bram_wr_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      ACLK,
   input  logic                      ARESETN,
   input  logic [NUM_REQ-1:0]        REQ_START,
   input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
   input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
   output logic [NUM_REQ-1:0]        REQ_DONE,
   output logic [NUM_REQ-1:0]        REQ_ERR,
   output logic                      WR_START,
   output logic [ADDR_W-1:0]         WR_ADDR,
   output logic [DATA_W-1:0]         WR_DATA,
   input  logic                      WR_DONE,
   output logic                      BUSY,
   output logic [2:0]                GRANT_IDX,
   output logic                      TIMEOUT_ERR,
   input  logic                      ERR_CLR
);

   localparam int              WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit              WD_EN    = (TIMEOUT_CYCLES > 0);
   localparam logic [WD_W-1:0] WD_LAST  = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [2:0]      PTR_INIT = 3'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_ACK   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                wr_start_q, wr_start_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [NUM_REQ-1:0]  done_q, done_d;
   logic [NUM_REQ-1:0]  err_q, err_d;
   logic                busy_q, busy_d;
   logic [2:0]          grant_q, grant_d;
   logic [2:0]          ptr_q, ptr_d;
   logic                tout_err_q, tout_err_d;
   logic [WD_W-1:0]     wd_q, wd_d;

   logic                any_req_s;
   logic                hi_found_s;
   logic [2:0]          hi_idx_s;
   logic [2:0]          lo_idx_s;
   logic [2:0]          pick_idx_s;
   logic [ADDR_W-1:0]   pick_addr_s;
   logic [DATA_W-1:0]   pick_data_s;
   logic [NUM_REQ-1:0]  grant_oh_s;

   // Rotating priority: lowest set bit above the pointer, else lowest set bit overall.
   always_comb begin
      any_req_s  = |REQ_START;
      hi_found_s = 1'b0;
      hi_idx_s   = 3'd0;
      lo_idx_s   = 3'd0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (REQ_START[i] && (3'(i) > ptr_q)) begin
            hi_found_s = 1'b1;
            hi_idx_s   = 3'(i);
         end else begin
            hi_found_s = hi_found_s;
         end
         if (REQ_START[i]) begin
            lo_idx_s = 3'(i);
         end else begin
            lo_idx_s = lo_idx_s;
         end
      end
      if (hi_found_s) begin
         pick_idx_s = hi_idx_s;
      end else begin
         pick_idx_s = lo_idx_s;
      end
   end

   // Select the winning requester's address/data slice and decode the current owner.
   always_comb begin
      pick_addr_s = '0;
      pick_data_s = '0;
      grant_oh_s  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (3'(i) == pick_idx_s) begin
            pick_addr_s = REQ_ADDR[i*ADDR_W +: ADDR_W];
            pick_data_s = REQ_DATA[i*DATA_W +: DATA_W];
         end else begin
            pick_addr_s = pick_addr_s;
         end
         grant_oh_s[i] = (grant_q == 3'(i));
      end
   end

   // Next-state and output logic of the arbitration FSM.
   always_comb begin
      state_d    = state_q;
      wr_start_d = wr_start_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      done_d     = '0;
      err_d      = '0;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      wd_d       = wd_q;
      tout_err_d = tout_err_q;

      if (ERR_CLR) begin
         tout_err_d = 1'b0;
      end else begin
         tout_err_d = tout_err_q;
      end

      case (state_q)
         S_IDLE: begin
            if (any_req_s) begin
               wr_addr_d  = pick_addr_s;
               wr_data_d  = pick_data_s;
               wr_start_d = 1'b1;
               grant_d    = pick_idx_s;
               ptr_d      = pick_idx_s;
               wd_d       = '0;
               state_d    = S_WRITE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            if (WD_EN) begin
               wd_d = wd_q + WD_W'(1);
            end else begin
               wd_d = wd_q;
            end
            // A completion in the same cycle as the watchdog expiry is a clean finish.
            if (WR_DONE) begin
               wr_start_d = 1'b0;
               done_d     = grant_oh_s;
               state_d    = S_ACK;
            end else if (WD_EN && (wd_q == WD_LAST)) begin
               wr_start_d = 1'b0;
               done_d     = grant_oh_s;
               err_d      = grant_oh_s;
               tout_err_d = 1'b1;
               state_d    = S_ACK;
            end else begin
               state_d = S_WRITE;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d    = S_IDLE;
            wr_start_d = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= S_IDLE;
         wr_start_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done_q     <= '0;
         err_q      <= '0;
         busy_q     <= 1'b0;
         grant_q    <= 3'd0;
         ptr_q      <= PTR_INIT;
         wd_q       <= '0;
         tout_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_start_q <= wr_start_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         done_q     <= done_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         wd_q       <= wd_d;
         tout_err_q <= tout_err_d;
      end
   end

   assign WR_START    = wr_start_q;
   assign WR_ADDR     = wr_addr_q;
   assign WR_DATA     = wr_data_q;
   assign REQ_DONE    = done_q;
   assign REQ_ERR     = err_q;
   assign BUSY        = busy_q;
   assign GRANT_IDX   = grant_q;
   assign TIMEOUT_ERR = tout_err_q;

endmodule
